// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, funct3 ops, bit positions, causes and FSM state for the commit unit
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam int BIT_MIE  = 3;
  localparam int BIT_MPIE = 7;
  localparam int BIT_MTIE = 7;
  localparam int BIT_MEIE = 11;

  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - flop-chain synchronizer for one asynchronous interrupt level
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/csr_commit_unit.sv
// rtl/csr_commit_unit.sv - MEM-stage CSR read/modify/write, mret, M-mode interrupts and PC redirect
module csr_commit_unit
  import csr_pkg::*;
#(
  parameter int          SYNC_STAGES  = 2,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] MTVEC_RESET  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_csr_en,
  input  logic [2:0]  mfunc3,
  input  logic [11:0] mem_csr_addr,
  input  logic [31:0] csr_wdata_mem,
  input  logic        is_mret_mem,
  input  logic [31:0] mpc,
  input  logic        ext_irq,
  input  logic        tmr_irq,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        suppress_wb
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          mie_bit, mpie_bit, mtie, meie, mtip, meip;
  logic [31:0]   mtvec, mscratch, mepc, mcause;
  logic [63:0]   mcycle;
  logic [31:0]   mstatus_val, mie_val, mip_val, nv;
  logic [31:0]   trap_base, trap_pc;
  logic [3:0]    cause;
  logic          csr_hit, wr_req, csr_we, irq_take, accepted, do_mret;

  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ext (.clk(clk), .rst(rst), .d(ext_irq), .q(meip));
  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tmr (.clk(clk), .rst(rst), .d(tmr_irq), .q(mtip));

  always_comb begin
    mstatus_val = 32'h0000_1800;
    mstatus_val[BIT_MIE]  = mie_bit;
    mstatus_val[BIT_MPIE] = mpie_bit;
    mie_val = '0;
    mie_val[BIT_MTIE] = mtie;
    mie_val[BIT_MEIE] = meie;
    mip_val = '0;
    mip_val[BIT_MTIE] = mtip;
    mip_val[BIT_MEIE] = meip;
  end

  always_comb begin
    csr_hit = 1'b1;
    case (mem_csr_addr)
      CSR_MSTATUS:  csr_rdata = mstatus_val;
      CSR_MIE:      csr_rdata = mie_val;
      CSR_MTVEC:    csr_rdata = mtvec;
      CSR_MSCRATCH: csr_rdata = mscratch;
      CSR_MEPC:     csr_rdata = mepc;
      CSR_MCAUSE:   csr_rdata = mcause;
      CSR_MIP:      csr_rdata = mip_val;
      CSR_MCYCLE:   csr_rdata = mcycle[31:0];
      CSR_MCYCLEH:  csr_rdata = mcycle[63:32];
      default: begin
        csr_rdata = '0;
        csr_hit   = 1'b0;
      end
    endcase
  end

  always_comb begin
    nv     = csr_rdata;
    wr_req = 1'b0;
    case (mfunc3)
      F3_CSRRW, F3_CSRRWI: begin nv = csr_wdata_mem;             wr_req = 1'b1;            end
      F3_CSRRS, F3_CSRRSI: begin nv = csr_rdata | csr_wdata_mem;  wr_req = |csr_wdata_mem; end
      F3_CSRRC, F3_CSRRCI: begin nv = csr_rdata & ~csr_wdata_mem; wr_req = |csr_wdata_mem; end
      default: ;
    endcase
  end

  assign csr_illegal = mem_csr_en & ~csr_hit;
  assign flush       = (state == FLUSH);
  assign irq_take    = mie_bit & ((meie & meip) | (mtie & mtip)) & mem_valid & ~flush;
  assign accepted    = mem_valid & ~flush & ~irq_take;
  assign csr_we      = accepted & mem_csr_en & csr_hit & wr_req;
  assign do_mret     = accepted & is_mret_mem;
  assign suppress_wb = irq_take | flush;
  assign cause       = (meie & meip) ? CAUSE_MEI : CAUSE_MTI;
  assign trap_base   = mtvec & ~32'h3;
  // Vectored mode jumps to base + 4*cause; any other stored mode is direct.
  assign trap_pc     = (mtvec[1:0] == 2'b01) ? trap_base + {26'd0, cause, 2'b00} : trap_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;       cnt <= '0;
      mie_bit <= 1'b0;    mpie_bit <= 1'b0;
      mtie <= 1'b0;       meie <= 1'b0;
      mtvec <= MTVEC_RESET;
      mscratch <= '0;     mepc <= '0;     mcause <= '0;
      mcycle <= '0;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
    end else begin
      // A write to either half replaces the increment; the other half holds.
      if (csr_we && mem_csr_addr == CSR_MCYCLE)       mcycle[31:0]  <= nv;
      else if (csr_we && mem_csr_addr == CSR_MCYCLEH) mcycle[63:32] <= nv;
      else                                            mcycle <= mcycle + 64'd1;

      if (csr_we) begin
        case (mem_csr_addr)
          CSR_MSTATUS:  begin mie_bit <= nv[BIT_MIE]; mpie_bit <= nv[BIT_MPIE]; end
          CSR_MIE:      begin mtie <= nv[BIT_MTIE];   meie <= nv[BIT_MEIE];     end
          CSR_MTVEC:    mtvec <= {nv[31:2], nv[1] ? 2'b00 : nv[1:0]};
          CSR_MSCRATCH: mscratch <= nv;
          CSR_MEPC:     mepc <= nv & ~32'h3;
          CSR_MCAUSE:   mcause <= nv;
          default: ;
        endcase
      end

      if (do_mret) begin
        mie_bit  <= mpie_bit;
        mpie_bit <= 1'b1;
      end

      if (irq_take) begin
        mepc     <= mpc & ~32'h3;
        mcause   <= {1'b1, 27'd0, cause};
        mpie_bit <= mie_bit;
        mie_bit  <= 1'b0;
      end

      redirect_valid <= 1'b0;
      case (state)
        RUN: if (irq_take || do_mret) begin
          state          <= FLUSH;
          cnt            <= CW'(FLUSH_CYCLES - 1);
          redirect_valid <= 1'b1;
          redirect_pc    <= irq_take ? trap_pc : mepc;
        end
        FLUSH: begin
          if (cnt == '0) state <= RUN;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_commit_unit.sv
// tb/tb_csr_commit_unit.sv - self-checking bench for csr_commit_unit
module tb_csr_commit_unit;

  logic        clk, rst, mem_valid, mem_csr_en, is_mret_mem, ext_irq, tmr_irq;
  logic [2:0]  mfunc3;
  logic [11:0] mem_csr_addr;
  logic [31:0] csr_wdata_mem, mpc, csr_rdata, redirect_pc;
  logic        csr_illegal, redirect_valid, flush, suppress_wb;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  typedef struct {
    logic        valid;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;
  vec_t vecs[29];

  csr_commit_unit dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_csr_en(mem_csr_en),
    .mfunc3(mfunc3), .mem_csr_addr(mem_csr_addr), .csr_wdata_mem(csr_wdata_mem),
    .is_mret_mem(is_mret_mem), .mpc(mpc), .ext_irq(ext_irq), .tmr_irq(tmr_irq),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .suppress_wb(suppress_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic ce, input logic [2:0] f3, input logic [11:0] a,
                       input logic [31:0] wd, input logic mret, input logic [31:0] pc);
    mem_valid = v; mem_csr_en = ce; mfunc3 = f3; mem_csr_addr = a;
    csr_wdata_mem = wd; is_mret_mem = mret; mpc = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a);
    drive(1'b1, 1'b1, 3'b010, a, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 12'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Redirect scoreboard: every pulse must match the oldest expected target.
  always @(posedge clk) begin
    #1;
    if (redirect_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_redirect: got pc %h expected no redirect", redirect_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        chk("redirect_pc", redirect_pc, exp_pc);
      end
    end
  end

  initial begin
    vecs[0]  = '{1'b1, 3'b010, 12'h305, 32'h0,        32'h0000_0100, 1'b0};
    vecs[1]  = '{1'b1, 3'b001, 12'h340, 32'hDEADBEEF, 32'h0,         1'b0};
    vecs[2]  = '{1'b1, 3'b011, 12'h340, 32'h0000FFFF, 32'hDEADBEEF,  1'b0};
    vecs[3]  = '{1'b1, 3'b010, 12'h340, 32'h0,        32'hDEAD0000,  1'b0};
    vecs[4]  = '{1'b1, 3'b001, 12'h7C0, 32'h1234,     32'h0,         1'b1};
    vecs[5]  = '{1'b1, 3'b010, 12'h300, 32'h0,        32'h0000_1800, 1'b0};
    vecs[6]  = '{1'b1, 3'b101, 12'h305, 32'h203,      32'h0000_0100, 1'b0};
    vecs[7]  = '{1'b1, 3'b010, 12'h305, 32'h0,        32'h0000_0200, 1'b0};
    vecs[8]  = '{1'b1, 3'b001, 12'h305, 32'h201,      32'h0000_0200, 1'b0};
    vecs[9]  = '{1'b1, 3'b001, 12'h341, 32'h123,      32'h0,         1'b0};
    vecs[10] = '{1'b1, 3'b010, 12'h341, 32'h0,        32'h0000_0120, 1'b0};
    vecs[11] = '{1'b1, 3'b001, 12'h344, 32'hFFFF,     32'h0,         1'b0};
    vecs[12] = '{1'b1, 3'b010, 12'h344, 32'h0,        32'h0,         1'b0};
    vecs[13] = '{1'b1, 3'b001, 12'h304, 32'h880,      32'h0,         1'b0};
    vecs[14] = '{1'b1, 3'b010, 12'h304, 32'h0,        32'h0000_0880, 1'b0};
    vecs[15] = '{1'b1, 3'b001, 12'h342, 32'h5,        32'h0,         1'b0};
    vecs[16] = '{1'b1, 3'b010, 12'h342, 32'h0,        32'h5,         1'b0};
    vecs[17] = '{1'b1, 3'b010, 12'h300, 32'h8,        32'h0000_1800, 1'b0};
    vecs[18] = '{1'b1, 3'b010, 12'h300, 32'h0,        32'h0000_1808, 1'b0};
    vecs[19] = '{1'b1, 3'b011, 12'h300, 32'h8,        32'h0000_1808, 1'b0};
    vecs[20] = '{1'b1, 3'b010, 12'h300, 32'h0,        32'h0000_1800, 1'b0};
    vecs[21] = '{1'b1, 3'b000, 12'h340, 32'h1,        32'hDEAD0000,  1'b0};
    vecs[22] = '{1'b1, 3'b010, 12'h340, 32'h0,        32'hDEAD0000,  1'b0};
    vecs[23] = '{1'b1, 3'b010, 12'h340, 32'h1,        32'hDEAD0000,  1'b0};
    vecs[24] = '{1'b1, 3'b010, 12'h340, 32'h0,        32'hDEAD0001,  1'b0};
    vecs[25] = '{1'b0, 3'b001, 12'h340, 32'h0,        32'hDEAD0001,  1'b0};
    vecs[26] = '{1'b1, 3'b010, 12'h340, 32'h0,        32'hDEAD0001,  1'b0};
    vecs[27] = '{1'b1, 3'b001, 12'h300, 32'h8,        32'h0000_1800, 1'b0};
    vecs[28] = '{1'b1, 3'b010, 12'h305, 32'h0,        32'h0000_0201, 1'b0};

    rst = 1'b1; ext_irq = 1'b0; tmr_irq = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset redirect_valid", {31'b0, redirect_valid}, 32'h0);
    chk("reset redirect_pc", redirect_pc, 32'h0);
    chk("reset flush", {31'b0, flush}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 29; i++) begin
      drive(vecs[i].valid, 1'b1, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 1'b0, 32'h0);
      #3;
      chk($sformatf("vec%0d rdata", i), csr_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d illegal", i), {31'b0, csr_illegal}, {31'b0, vecs[i].exp_ill});
      step();
    end

    // Both irqs raised; visible after two synchronizer edges, external wins.
    drive(1'b1, 1'b0, 3'b000, 12'h0, 32'h0, 1'b0, 32'h40);
    ext_irq = 1'b1; tmr_irq = 1'b1;
    #3 chk("irq sync edge0", {31'b0, suppress_wb}, 32'h0); step();
    #3 chk("irq sync edge1", {31'b0, suppress_wb}, 32'h0); step();
    #3 chk("irq take", {31'b0, suppress_wb}, 32'h1);
    exp_q.push_back(32'h0000_022C);
    step();
    ext_irq = 1'b0; tmr_irq = 1'b0;
    rd(12'h342); #3;
    chk("irq flush1", {31'b0, flush}, 32'h1);
    chk("irq mcause", csr_rdata, 32'h8000_000B); step();
    rd(12'h341); #3;
    chk("irq flush2", {31'b0, flush}, 32'h1);
    chk("irq mepc", csr_rdata, 32'h40); step();
    rd(12'h300); #3;
    chk("irq flush end", {31'b0, flush}, 32'h0);
    chk("irq mstatus", csr_rdata, 32'h0000_1880); step();

    // mret, with a write attempted while flushing.
    drive(1'b1, 1'b0, 3'b000, 12'h0, 32'h0, 1'b1, 32'h60);
    #3 chk("mret suppress", {31'b0, suppress_wb}, 32'h0);
    exp_q.push_back(32'h40);
    step();
    drive(1'b1, 1'b1, 3'b001, 12'h340, 32'h77, 1'b0, 32'h0);
    #3 chk("mret flush1", {31'b0, flush}, 32'h1); step();
    idle();
    #3 chk("mret flush2", {31'b0, flush}, 32'h1); step();
    rd(12'h300); #3;
    chk("mret flush end", {31'b0, flush}, 32'h0);
    chk("mret mstatus", csr_rdata, 32'h0000_1888); step();
    rd(12'h340);
    #3 chk("flush write dropped", csr_rdata, 32'hDEAD0001); step();

    // Timer interrupt coinciding with mret and a mscratch write.
    idle(); tmr_irq = 1'b1; step();
    step();
    drive(1'b1, 1'b1, 3'b001, 12'h340, 32'h99, 1'b1, 32'h80);
    #3 chk("coincide suppress", {31'b0, suppress_wb}, 32'h1);
    exp_q.push_back(32'h0000_021C);
    step();
    tmr_irq = 1'b0;
    rd(12'h342); #3 chk("coincide mcause", csr_rdata, 32'h8000_0007); step();
    rd(12'h341); #3 chk("coincide mepc", csr_rdata, 32'h80); step();
    rd(12'h340); #3 chk("coincide mscratch", csr_rdata, 32'hDEAD0001); step();
    rd(12'h300); #3 chk("coincide mstatus", csr_rdata, 32'h0000_1880); step();

    // Reset in the middle of a flush.
    drive(1'b1, 1'b0, 3'b000, 12'h0, 32'h0, 1'b1, 32'h0);
    exp_q.push_back(32'h80);
    step();
    idle();
    #1 chk("pre-reset flush", {31'b0, flush}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("mid-flush reset flush", {31'b0, flush}, 32'h0);
    chk("mid-flush reset redirect_valid", {31'b0, redirect_valid}, 32'h0);
    chk("mid-flush reset redirect_pc", redirect_pc, 32'h0);
    step();
    rst = 1'b0;
    rd(12'h305); #3 chk("post-reset mtvec", csr_rdata, 32'h0000_0100); step();
    rd(12'h340); #3 chk("post-reset mscratch", csr_rdata, 32'h0); step();
    rd(12'h300); #3 chk("post-reset mstatus", csr_rdata, 32'h0000_1800); step();

    // mcycle carry into mcycleh, then a direct write to the high half.
    drive(1'b1, 1'b1, 3'b001, 12'hB00, 32'hFFFF_FFFF, 1'b0, 32'h0); step();
    rd(12'hB80); #3 chk("mcycleh before carry", csr_rdata, 32'h0); step();
    rd(12'hB80); #3 chk("mcycleh after carry", csr_rdata, 32'h1); step();
    drive(1'b1, 1'b1, 3'b001, 12'hB80, 32'h5, 1'b0, 32'h0); step();
    rd(12'hB80); #3 chk("mcycleh written", csr_rdata, 32'h5); step();
    idle();
    step();

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_redirect: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
